// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder, one BLOCK-bit group per stage.
// Optional subtract mode is compiled in with `define CLA_SUB_EN.
module cla_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NST = WIDTH / BLOCK;

   // One transaction in flight: valid, group carry, operands, partial sum.
   typedef struct packed {
      logic             v;
      logic             c;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] s;
   } stg_t;

   stg_t src;
   stg_t st_q [NST];
   stg_t st_d [NST];
   logic adv;
   logic sub_e;

   // Flat lookahead: each carry is a sum of products of g, p and the group carry-in.
   function automatic logic [BLOCK:0] grp_add(
      input logic [BLOCK-1:0] x,
      input logic [BLOCK-1:0] y,
      input logic             ci
   );
      logic [BLOCK-1:0] g;
      logic [BLOCK-1:0] p;
      logic [BLOCK:0]   c;
      logic             t;
      g = x & y;
      p = x ^ y;
      c = '0;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         t = ci;
         for (int j = 0; j <= i; j++) t = t & p[j];
         c[i+1] = t;
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int m = j + 1; m <= i; m++) t = t & p[m];
            c[i+1] = c[i+1] | t;
         end
      end
      return {c[BLOCK], p ^ c[BLOCK-1:0]};
   endfunction

`ifdef CLA_SUB_EN
   assign sub_e = sub;
`else
   assign sub_e = 1'b0;
`endif

   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // Incoming operands with the effective B and carry-in already applied.
   always_comb begin
      src   = '0;
      src.v = in_valid;
      src.c = cin ^ sub_e;
      src.a = a;
      src.b = b ^ {WIDTH{sub_e}};
   end

   for (genvar k = 0; k < NST; k++) begin : g_stg
      stg_t           prev;
      stg_t           nxt;
      logic [BLOCK:0] r;

      if (k == 0) begin : g_first
         assign prev = src;
      end else begin : g_next
         assign prev = st_q[k-1];
      end

      assign r = grp_add(prev.a[k*BLOCK +: BLOCK],
                         prev.b[k*BLOCK +: BLOCK], prev.c);

      // Resolve group k and pass everything else along.
      always_comb begin
         nxt                      = prev;
         nxt.c                    = r[BLOCK];
         nxt.s[k*BLOCK +: BLOCK]  = r[BLOCK-1:0];
      end

      assign st_d[k] = nxt;
   end

   // Whole pipeline advances together; a stall freezes every stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NST; k++) st_q[k] <= '0;
      end else if (adv) begin
         for (int k = 0; k < NST; k++) st_q[k] <= st_d[k];
      end
   end

   assign out_valid = st_q[NST-1].v;
   assign sum       = st_q[NST-1].s;
   assign cout      = st_q[NST-1].c;
   assign ovf       = (st_q[NST-1].a[WIDTH-1] == st_q[NST-1].b[WIDTH-1]) &&
                      (st_q[NST-1].s[WIDTH-1] != st_q[NST-1].a[WIDTH-1]);

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: vector table, handshake sequences and random scoreboard
// checks for cla_adder_pipe at 16/4, 32/8 and 8/8.
module tb_cla_adder_pipe;

   localparam int W   = 16;
   localparam int B   = 4;
   localparam int NST = W / B;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cla_adder_pipe #(.WIDTH(W), .BLOCK(B)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef CLA_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   vec_t         vt[$];
   exp_t         q[$];
   int           acc_n = 0;
   int           pop_n = 0;
   logic         held = 1'b0;
   logic [W-1:0] h_s;
   logic         h_co;
   logic         h_ov;

   // Reference: plain integer arithmetic; returns {ovf, cout, sum[31:0]}.
   function automatic logic [33:0] ref_add(int w, longint unsigned x,
                                           longint unsigned y, bit c, bit s);
      longint unsigned mask, half, xx, yy, tot;
      longint          sx, sy, st;
      bit              ci;
      logic [33:0]     r;
      mask = (64'd1 << w) - 1;
      half = 64'd1 << (w - 1);
      ci   = c ^ s;
      xx   = x & mask;
      yy   = s ? (~y & mask) : (y & mask);
      tot  = xx + yy + longint'(ci);
      sx   = (xx >= half) ? longint'(xx) - longint'(2 * half) : longint'(xx);
      sy   = (yy >= half) ? longint'(yy) - longint'(2 * half) : longint'(yy);
      st   = sx + sy + longint'(ci);
      r        = '0;
      r[31:0]  = 32'(tot & mask);
      r[32]    = ((tot >> w) & 1) != 0;
      r[33]    = (st < -longint'(half)) || (st >= longint'(half));
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock: sample handshakes after inputs settle, then advance.
   task automatic tick();
      exp_t        e;
      logic [33:0] r;
      #1;
      if (held) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_sum", sum, h_s);
         chk("hold_cout", cout, h_co);
         chk("hold_ovf", ovf, h_ov);
      end
      held = out_valid && !out_ready;
      h_s  = sum;
      h_co = cout;
      h_ov = ovf;
      if (in_valid && in_ready) begin
         r = ref_add(W, 64'(a), 64'(b), cin, sub);
         q.push_back('{r[W-1:0], r[32], r[33]});
         acc_n++;
      end
      if (out_valid && out_ready) begin
         pop_n++;
         if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            e = q.pop_front();
            chk("sb_sum", sum, e.s);
            chk("sb_cout", cout, e.co);
            chk("sb_ovf", ovf, e.ov);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(vec_t v);
      int n;
      a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         tick();
         n++;
      end
      chk("latency", n, NST);
      chk("tbl_sum", sum, v.s);
      chk("tbl_cout", cout, v.co);
      chk("tbl_ovf", ovf, v.ov);
      tick();
   endtask

   initial begin
      int p0;
      int n;
      vt.push_back('{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0});
      vt.push_back('{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1});
      vt.push_back('{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1});
      vt.push_back('{16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0});
      vt.push_back('{16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0});
      vt.push_back('{16'h0000, 16'h0000, 1, 0, 16'h0001, 0, 0});
`ifdef CLA_SUB_EN
      vt.push_back('{16'd5, 16'd7, 0, 1, 16'hFFFE, 0, 0});
      vt.push_back('{16'd7, 16'd5, 0, 1, 16'd2, 1, 0});
`endif

      rst_n     = 1'b0;
      in_valid  = 1'b1;
      a         = 16'hFFFF;
      b         = 16'h0001;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      foreach (vt[i]) run_vec(vt[i]);

      // Back-pressure mid-stream.
      acc_n = 0;
      p0    = pop_n;
      for (int t = 0; t < 12; t++) begin
         in_valid  = (acc_n < 6);
         a         = W'($urandom);
         b         = W'($urandom);
         cin       = 1'($urandom);
         out_ready = !(t >= 5 && t <= 7);
         if (t >= 5 && t <= 7) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((pop_n - p0) < 6 && n < 40) begin
         tick();
         n++;
      end
      chk("bp_count", pop_n - p0, 6);
      chk("bp_queue_empty", q.size(), 0);

      // Reset with transactions in flight.
      in_valid = 1'b1;
      repeat (3) begin
         a = W'($urandom);
         b = W'($urandom);
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      q.delete();
      held = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_vec(vt[0]);

      // Random traffic with random back-pressure.
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = W'($urandom);
         b         = W'($urandom);
         cin       = 1'($urandom);
`ifdef CLA_SUB_EN
         sub       = 1'($urandom);
`endif
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("rnd_drain", q.size(), 0);

      wait (g_rnd[0].done && g_rnd[1].done);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Random scoreboard on other geometries, including single-stage.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
      localparam int RW = (gi == 0) ? 32 : 8;
      localparam int RB = 8;

      logic          r_rst_n;
      logic          r_iv;
      logic          r_ir;
      logic [RW-1:0] r_a;
      logic [RW-1:0] r_b;
      logic          r_ci;
      logic          r_sb;
      logic          r_ov;
      logic          r_or;
      logic [RW-1:0] r_s;
      logic          r_co;
      logic          r_of;
      bit            done = 1'b0;
      logic [33:0]   rq[$];

      cla_adder_pipe #(.WIDTH(RW), .BLOCK(RB)) u_dut (
         .clk       (clk),
         .rst_n     (r_rst_n),
         .in_valid  (r_iv),
         .in_ready  (r_ir),
         .a         (r_a),
         .b         (r_b),
         .cin       (r_ci),
`ifdef CLA_SUB_EN
         .sub       (r_sb),
`endif
         .out_valid (r_ov),
         .out_ready (r_or),
         .sum       (r_s),
         .cout      (r_co),
         .ovf       (r_of)
      );

      initial begin
         logic [33:0] e;
         int          n;
         r_rst_n = 1'b0;
         r_iv    = 1'b0;
         r_a     = '0;
         r_b     = '0;
         r_ci    = 1'b0;
         r_sb    = 1'b0;
         r_or    = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         r_rst_n = 1'b1;
         for (int i = 0; i < 10000 + 60; i++) begin
            r_iv = (i < 10000) && ($urandom_range(0, 3) != 0);
            r_a  = RW'($urandom);
            r_b  = RW'($urandom);
            r_ci = 1'($urandom);
`ifdef CLA_SUB_EN
            r_sb = 1'($urandom);
`endif
            r_or = (i >= 10000) || ($urandom_range(0, 9) < 7);
            #1;
            if (r_iv && r_ir)
               rq.push_back(ref_add(RW, 64'(r_a), 64'(r_b), r_ci, r_sb));
            if (r_ov && r_or) begin
               if (rq.size() == 0) begin
                  chk("rnd_spurious", 1, 0);
               end else begin
                  e = rq.pop_front();
                  chk("rnd_sum", 64'(r_s), 64'(e[RW-1:0]));
                  chk("rnd_cout", r_co, e[32]);
                  chk("rnd_ovf", r_of, e[33]);
               end
            end
            @(posedge clk);
            #1;
         end
         n = rq.size();
         chk("rnd_g_drain", n, 0);
         done = 1'b1;
      end
   end

endmodule
